wb_write_arbiter: RTL

//  Shares the register-file write port between the pipeline write-back (MEM/WB output)
//  and a multi-cycle unit (MCU, e.g. mul/div) that returns results out of band.

---
 rtl/wb_write_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back versus buffered results
// from a multi-cycle unit, with starvation stall and a pending-register mask.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        PIPE_WE,
  input  logic [4:0]  PIPE_WREG,
  input  logic [31:0] PIPE_WDATA,
  input  logic        MCU_VALID,
  input  logic [4:0]  MCU_WREG,
  input  logic [31:0] MCU_WDATA,
  output logic        MCU_READY,
  output logic        PIPE_STALL,
  output logic [31:0] PEND_MASK,
  output logic        RF_WE,
  output logic [4:0]  RF_WREG,
  output logic [31:0] RF_WDATA
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT_CNT = SW'(STARVE_LIMIT);

  logic [4:0]       wregMem [DEPTH];
  logic [31:0]      dataMem [DEPTH];
  logic [DEPTH-1:0] validMem;
  logic [DEPTH-1:0] validNext;
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic [AW:0]      count;
  logic [SW-1:0]    starveCnt;
  logic [SW-1:0]    starveNext;
  logic [31:0]      pendMask;

  logic empty;
  logic full;
  logic headValid;
  logic pipeReq;
  logic store;
  logic grantFifo;
  logic grantPipe;
  logic pop;

  // MCU handshake: a result transfers on any edge where MCU_VALID && MCU_READY;
  // MCU_READY comes from registered occupancy only and never looks at MCU_VALID.
  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign headValid  = validMem[rdPtr];
  assign MCU_READY  = !RESET && !full;
  assign PIPE_STALL = !RESET && !empty && headValid && (starveCnt == LIMIT_CNT);

  assign pipeReq   = PIPE_WE && (PIPE_WREG != 5'd0) && !PIPE_STALL;
  assign store     = MCU_VALID && MCU_READY && (MCU_WREG != 5'd0);
  assign grantFifo = PIPE_STALL || (!pipeReq && !empty && headValid);
  assign grantPipe = pipeReq;
  // An invalidated head leaves without using the write port.
  assign pop       = !empty && (!headValid || grantFifo);

  always_comb begin
    validNext = validMem;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipeReq && (wregMem[i] == PIPE_WREG)) validNext[i] = 1'b0;
    end
    if (pop)   validNext[rdPtr] = 1'b0;
    // The same-cycle MCU result is younger than the pipeline write, so it stays valid.
    if (store) validNext[wrPtr] = 1'b1;
  end

  always_comb begin
    starveNext = starveCnt;
    if (grantFifo || empty || !headValid) starveNext = '0;
    else if (starveCnt != LIMIT_CNT)      starveNext = starveCnt + 1'b1;
  end

  always_comb begin
    pendMask = '0;
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (validMem[i]) pendMask[wregMem[i]] = 1'b1;
      end
    end
  end
  assign PEND_MASK = pendMask;

  always_ff @(posedge CLOCK) begin
    if (store) begin
      wregMem[wrPtr] <= MCU_WREG;
      dataMem[wrPtr] <= MCU_WDATA;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      validMem  <= '0;
      starveCnt <= '0;
      RF_WE     <= 1'b0;
      RF_WREG   <= '0;
      RF_WDATA  <= '0;
    end else begin
      validMem  <= validNext;
      starveCnt <= starveNext;
      RF_WE     <= grantFifo || grantPipe;
      if (grantFifo) begin
        RF_WREG  <= wregMem[rdPtr];
        RF_WDATA <= dataMem[rdPtr];
      end else if (grantPipe) begin
        RF_WREG  <= PIPE_WREG;
        RF_WDATA <= PIPE_WDATA;
      end
      if (pop)   rdPtr <= rdPtr + 1'b1;
      if (store) wrPtr <= wrPtr + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
